// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// It holds the architectural HI/LO registers and supports MTHI/MTLO writes.
// Each operation runs 32 single-bit iterations (shift-add or restoring
// shift-subtract), then one sign-fix/commit cycle. HI/LO are written only
// in that commit cycle.
// Optional feature: define MULDIV_ABORT_EN to add an abort input that
// cancels an in-flight operation without touching HI/LO.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
`ifdef MULDIV_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;
    logic [XLEN-1:0]     mag_a_reg, mag_a_next;
    logic [XLEN-1:0]     mag_b_reg, mag_b_next;
    logic                is_div_reg, is_div_next;
    logic                neg_res_reg, neg_res_next;
    logic                neg_rem_reg, neg_rem_next;
    logic                div_zero_reg, div_zero_next;
    logic [XLEN-1:0]     hi_reg, hi_next;
    logic [XLEN-1:0]     lo_reg, lo_next;
    logic                done_reg, done_next;

    // Operand decode at issue: op[0]=0 selects the signed variants.
    logic            signed_op;
    logic [XLEN-1:0] abs_a, abs_b;

    // Datapath for one iteration of either algorithm.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_rem_sh;
    logic [XLEN-1:0]   div_sub;
    logic              div_ok;
    logic [2*XLEN-1:0] div_step;

    // Sign-corrected results for the commit cycle.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, dividend_orig;

    // Operand magnitudes and the per-iteration step values.
    always_comb begin
        signed_op = ~op[0];
        abs_a     = (signed_op && a[XLEN-1]) ? -a : a;
        abs_b     = (signed_op && b[XLEN-1]) ? -b : b;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                   {1'b0, (acc_reg[0] ? mag_a_reg : {XLEN{1'b0}})};
        mul_step = {mul_sum, acc_reg[XLEN-1:1]};

        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        // The remainder is always < divisor, so the shifted value needs
        // one extra bit and the difference fits back into XLEN bits.
        div_rem_sh = acc_reg[2*XLEN-1:XLEN-1];
        div_ok     = (div_rem_sh >= {1'b0, mag_b_reg});
        div_sub    = div_rem_sh[XLEN-1:0] - mag_b_reg;
        div_step   = {(div_ok ? div_sub : div_rem_sh[XLEN-1:0]),
                      acc_reg[XLEN-2:0], div_ok};

        // Negating a zero product yields zero, so no separate zero test.
        prod_fix      = neg_res_reg ? -acc_reg : acc_reg;
        quot_fix      = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_fix       = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        dividend_orig = neg_rem_reg ? -mag_a_reg : mag_a_reg;
    end

    // Next-state and datapath control for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        acc_next      = acc_reg;
        mag_a_next    = mag_a_reg;
        mag_b_next    = mag_b_reg;
        is_div_next   = is_div_reg;
        neg_res_next  = neg_res_reg;
        neg_rem_next  = neg_rem_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle mthi/mtlo.
                    is_div_next   = op[1];
                    mag_a_next    = abs_a;
                    mag_b_next    = abs_b;
                    neg_res_next  = signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                    neg_rem_next  = signed_op & a[XLEN-1];
                    div_zero_next = (b == {XLEN{1'b0}});
                    acc_next      = op[1] ? {{XLEN{1'b0}}, abs_a}
                                          : {{XLEN{1'b0}}, abs_b};
                    count_next    = '0;
                    state_next    = S_RUN;
                end else begin
                    if (mthi) hi_next = a;
                    if (mtlo) lo_next = a;
                end
            end
            S_RUN: begin
                acc_next = is_div_reg ? div_step : mul_step;
                if (count_reg == CW'(XLEN - 1)) begin
                    state_next = S_FIX;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_FIX: begin
                if (!is_div_reg) begin
                    hi_next = prod_fix[2*XLEN-1:XLEN];
                    lo_next = prod_fix[XLEN-1:0];
                end else if (div_zero_reg) begin
                    // Divide by zero: all-ones quotient, dividend kept in HI.
                    hi_next = dividend_orig;
                    lo_next = {XLEN{1'b1}};
                end else begin
                    hi_next = rem_fix;
                    lo_next = quot_fix;
                end
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

`ifdef MULDIV_ABORT_EN
        // Abort cancels any in-flight op, including the commit cycle.
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            hi_next    = hi_reg;
            lo_next    = lo_reg;
            done_next  = 1'b0;
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            mag_a_reg    <= '0;
            mag_b_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            acc_reg      <= acc_next;
            mag_a_reg    <= mag_a_next;
            mag_b_reg    <= mag_b_next;
            is_div_reg   <= is_div_next;
            neg_res_reg  <= neg_res_next;
            neg_rem_reg  <= neg_rem_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
`ifdef MULDIV_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
`ifdef MULDIV_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Issue one op at the current falling edge and follow it to done.
    // lat counts falling edges after the start edge; 100 means no done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output logic leak);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op = o; a = x; b = y; start = 1'b1;
        lat = 0; bcnt = 0; leak = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            if (lat == 0) start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (!done && (hi !== h0 || lo !== l0)) leak = 1'b1;
            if (done) break;
        end
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d busy_cycles=%0d",
                 o, x, y, hi, lo, lat, bcnt);
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%08h exp=00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%08h exp=00000000", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        // Preload HI/LO together so the mid-op reset has something to clear.
        a = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        $display("mthi+mtlo a=a5a5a5a5 -> hi=%08h lo=%08h", hi, lo);
        checks++; if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_mtlo_hi got=%08h exp=a5a5a5a5", hi); end
        checks++; if (lo !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_mtlo_lo got=%08h exp=a5a5a5a5", lo); end
        // MULTU 7*9, reset while the counter reads 10.
        op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid MULTU -> hi=%08h lo=%08h busy=%b", hi, lo, busy);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL midreset_hi got=%08h exp=00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo got=%08h exp=00000000", lo); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midreset_lo_hold got=%08h exp=00000000", lo); end
    endtask

    task automatic test_mult();
        int lat, bcnt; logic leak;
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, bcnt, leak);
        checks++; if (lat !== 34) begin failures++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        checks++; if (bcnt !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bcnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done got=%b exp=0", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%08h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%08h exp=fffffff1", lo); end
        checks++; if (leak !== 1'b0) begin failures++; $display("FAIL mult_hilo_leak got=%b exp=0", leak); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; logic leak;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, leak);
        checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%08h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%08h exp=00000001", lo); end
        // Started in the done cycle of the previous op.
        do_op(2'b11, 32'd100, 32'd7, lat, bcnt, leak);
        checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        checks++; if (lo !== 32'h0000000E) begin failures++; $display("FAIL divu_lo got=%08h exp=0000000e", lo); end
        checks++; if (hi !== 32'h00000002) begin failures++; $display("FAIL divu_hi got=%08h exp=00000002", hi); end
        checks++; if (leak !== 1'b0) begin failures++; $display("FAIL b2b_hilo_leak got=%b exp=0", leak); end
    endtask

    task automatic test_div();
        int lat, bcnt; logic leak;
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bcnt, leak);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%08h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%08h exp=ffffffff", hi); end
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, leak);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%08h exp=80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%08h exp=00000000", hi); end
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, bcnt, leak);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negb_lo got=%08h exp=fffffffd", lo); end
        checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL div_negb_hi got=%08h exp=00000001", hi); end
    endtask

    task automatic test_div_zero();
        int lat, bcnt; logic leak;
        do_op(2'b11, 32'h12345678, 32'h0, lat, bcnt, leak);
        checks++; if (lat !== 34) begin failures++; $display("FAIL divz_latency got=%0d exp=34", lat); end
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divuz_lo got=%08h exp=ffffffff", lo); end
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL divuz_hi got=%08h exp=12345678", hi); end
        do_op(2'b10, 32'hFFFFFFF9, 32'h0, lat, bcnt, leak);
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_lo got=%08h exp=ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin failures++; $display("FAIL divz_hi got=%08h exp=fffffff9", hi); end
    endtask

    task automatic test_busy_ignore();
        int lat, bcnt;
        op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
        lat = 0; bcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            start = 1'b0; mthi = 1'b0;
            if (lat >= 3 && lat <= 6) begin
                start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
            end
            if (lat == 8) begin
                mthi = 1'b1; a = 32'h0000DEAD;
            end
            if (busy) bcnt++;
            if (done) break;
        end
        start = 1'b0; mthi = 1'b0;
        $display("MULTU 6*7 with start/mthi while busy -> hi=%08h lo=%08h lat=%0d", hi, lo, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL busy_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL busy_hi got=%08h exp=00000000", hi); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL busy_lo got=%08h exp=0000002a", lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_mtlo();
        // HI is 0 from the previous MULTU 6*7.
        a = 32'hCAFEF00D; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        $display("mtlo a=cafef00d -> hi=%08h lo=%08h", hi, lo);
        checks++; if (lo !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_lo got=%08h exp=cafef00d", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mtlo_hi got=%08h exp=00000000", hi); end
    endtask

    task automatic test_start_mthi();
        int lat;
        a = 32'h11111111; mthi = 1'b1;
        @(negedge clk);
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== 32'h11111111) begin failures++; $display("FAIL start_mthi_hi got=%08h exp=11111111", hi); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_mthi_busy got=%b exp=1", busy); end
        lat = 1;
        while (lat < 100 && !done) begin
            @(negedge clk);
            lat++;
        end
        $display("MULTU 3*4 with mthi -> hi=%08h lo=%08h lat=%0d", hi, lo, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL start_mthi_latency got=%0d exp=34", lat); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL start_mthi_res_hi got=%08h exp=00000000", hi); end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL start_mthi_res_lo got=%08h exp=0000000c", lo); end
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort();
        logic seen;
        a = 32'h13579BDF; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0; a = 32'h2468ACE0; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort at count 5 -> hi=%08h lo=%08h busy=%b", hi, lo, busy);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        checks++; if (hi !== 32'h13579BDF) begin failures++; $display("FAIL abort_hi got=%08h exp=13579bdf", hi); end
        checks++; if (lo !== 32'h2468ACE0) begin failures++; $display("FAIL abort_lo got=%08h exp=2468ace0", lo); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_mtlo();
        test_start_mthi();
`ifdef MULDIV_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
